// File: rtl/alu16_pkg.sv
// Shared widths, FSM states and command payload for the alu16 initiator-side driver.
package alu16_pkg;

    localparam int unsigned ALU_W = 16;
    localparam int unsigned OP_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } drv_state_e;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [OP_W-1:0]  op;
    } alu_cmd_t;

endpackage

// File: rtl/alu16_cmd_fifo.sv
// Command FIFO for the alu16 driver: power-of-two depth, first-word-fall-through read,
// occupancy count drives full/empty.
module alu16_cmd_fifo
    import alu16_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  alu_cmd_t wdata_i,
    input  logic     pop_i,
    output alu_cmd_t rdata_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    alu_cmd_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu16_driver.sv
// Sequencer that owns alu16 port timing: buffers commands, issues one at a time,
// follows busy with a timeout, and returns results in order on a valid/ready port.
module alu16_driver
    import alu16_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [ALU_W-1:0] cmd_a_i,
    input  logic [ALU_W-1:0] cmd_b_i,
    input  logic [OP_W-1:0]  cmd_op_i,
    output logic [ALU_W-1:0] alu_inputR1_o,
    output logic [ALU_W-1:0] alu_inputR2_o,
    output logic [OP_W-1:0]  alu_instruction_o,
    input  logic [ALU_W-1:0] alu_outputR_i,
    input  logic             alu_busy_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [ALU_W-1:0] res_data_o,
    output logic [OP_W-1:0]  res_op_o,
    output logic             res_err_o,
    output logic             idle_o
);

    localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(MAX_WAIT);

    drv_state_e        state_q;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic [ALU_W-1:0]  alu_r1_q;
    logic [ALU_W-1:0]  alu_r2_q;
    logic [OP_W-1:0]   alu_ins_q;
    logic              res_valid_q;
    logic [ALU_W-1:0]  res_data_q;
    logic [OP_W-1:0]   res_op_q;
    logic              res_err_q;

    alu_cmd_t          cmd_in;
    alu_cmd_t          head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop_c;

    assign cmd_in = '{a: cmd_a_i, b: cmd_b_i, op: cmd_op_i};
    assign pop_c  = (state_q == IDLE) && !fifo_empty;

    alu16_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_valid_i),
        .wdata_i (cmd_in),
        .pop_i   (pop_c),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // One operation in flight; ALU ports only move on the IDLE->ISSUE step.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            alu_r1_q    <= '0;
            alu_r2_q    <= '0;
            alu_ins_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        alu_r1_q  <= head.a;
                        alu_r2_q  <= head.b;
                        alu_ins_q <= head.op;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    wait_cnt_q <= (wait_cnt_q == WAIT_MAX) ? wait_cnt_q
                                                           : wait_cnt_q + WCNT_W'(1);
                    if (!alu_busy_i) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= alu_outputR_i;
                        res_op_q    <= alu_ins_q;
                        res_err_q   <= 1'b0;
                        state_q     <= HOLD;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        // Counter reaches MAX_WAIT on this edge: report a timeout.
                        res_valid_q <= 1'b1;
                        res_data_q  <= '0;
                        res_op_q    <= alu_ins_q;
                        res_err_q   <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o       = !fifo_full;
    assign idle_o            = fifo_empty && (state_q == IDLE);
    assign alu_inputR1_o     = alu_r1_q;
    assign alu_inputR2_o     = alu_r2_q;
    assign alu_instruction_o = alu_ins_q;
    assign res_valid_o       = res_valid_q;
    assign res_data_o        = res_data_q;
    assign res_op_o          = res_op_q;
    assign res_err_o         = res_err_q;

endmodule

// File: doc/alu16_driver.md
# alu16_driver

Initiator-side sequencer for the 16-bit ALU `alu16`. It accepts operation commands from upstream on a valid/ready interface and buffers them in a small FIFO. It issues each command to the ALU by driving its operand and instruction ports, follows the ALU's `busy` handshake, and returns each captured result downstream on a valid/ready interface. It sits between the control path and the ALU and owns all ALU port timing.

## Interface
- `DEPTH`, default 4: command FIFO entries, power of two, minimum 2.
- `MAX_WAIT`, default 64: maximum cycles `busy` may stay high before a timeout.
- `CK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept; equals not-full.
- `cmd_a` in 16: operand 1.
- `cmd_b` in 16: operand 2.
- `cmd_op` in 3: ALU instruction.
- `alu_inputR1` out 16: to `alu16.inputR1`.
- `alu_inputR2` out 16: to `alu16.inputR2`.
- `alu_instruction` out 3: to `alu16.instruction`.
- `alu_outputR` in 16: from `alu16.outputR`.
- `alu_busy` in 1: from `alu16.busy`.
- `res_valid` out 1: result present.
- `res_ready` in 1: downstream accepts.
- `res_data` out 16: captured ALU result.
- `res_op` out 3: instruction that produced the result.
- `res_err` out 1: result is a timeout.
- `idle` out 1: FIFO empty and FSM in IDLE.

## Operation
- Command push on `cmd_valid && cmd_ready`. A push into a full FIFO is impossible because `cmd_ready` is low. A pop in the same cycle does not raise `cmd_ready` combinationally.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head, register it onto `alu_*`, go to ISSUE.
  - ISSUE: hold operands for exactly one cycle so the ALU samples them, then go to WAIT.
  - WAIT:
    - If `alu_busy`==0, capture `alu_outputR` into `res_data`, set `res_op`, clear `res_err`, assert `res_valid`, go to HOLD.
    - If `alu_busy` remains 1 when the wait counter reaches `MAX_WAIT`, set `res_data`=16'h0000 and `res_err`=1, assert `res_valid`, go to HOLD.
  - HOLD: keep `res_*` stable until `res_ready`. On the handshake, deassert `res_valid` and go to IDLE.
- `alu_*` outputs change only on an IDLE→ISSUE transition. Between operations they keep the last issued values.
- Only one operation is ever in flight. Results return in command order.
- The wait counter is `$clog2(MAX_WAIT+1)` bits. It clears on entry to WAIT, increments each WAIT cycle, and saturates.

## Timing
- Reset values:
  - `alu_inputR1`/`alu_inputR2`=0 and `alu_instruction`=0.
  - `res_valid`=0, `res_data`=0, `res_op`=0, `res_err`=0.
  - `cmd_ready`=1 and `idle`=1.
  - FIFO empty, FSM in IDLE.
- Minimum latency:
  - Command pushed at edge E0.
  - Popped and driven to the ALU at E1.
  - WAIT entered at E2.
  - Result captured at E3 if `busy` is low, so `res_valid` is high after E3.
- Each extra cycle of `alu_busy`=1 sampled in WAIT adds one cycle.
- A timeout asserts `res_valid` at the edge where the counter reaches `MAX_WAIT`.
- Reset mid-operation in any state: the FIFO is flushed and the in-flight operation is discarded. No result is produced, and all outputs return to their reset values immediately (asynchronous).
- `res_valid` never drops without `res_ready`, and `res_*` never change while `res_valid`=1.
- Minimum issue spacing is 4 cycles per operation (IDLE→ISSUE→WAIT→HOLD→IDLE) with `res_ready` tied high.

## Structure
- Package `alu16_pkg`:
  - `ALU_W`=16 and `OP_W`=3.
  - FSM state enum (IDLE, ISSUE, WAIT, HOLD).
  - Command struct {a, b, op}.
- Sub-module `alu16_cmd_fifo`:
  - Synchronous `DEPTH`-entry FIFO of the command struct.
  - Read/write pointers and a count.
  - Outputs `full` and `empty`.
  - Asynchronous active-high reset.
- The FSM, wait counter and result registers live in `alu16_driver`.

## Test plan
All scenarios use a bench behavioural ALU stub.
- **No-busy operation:** push a=16'h000A, b=16'h0009, op=3'b011; stub returns outputR=16'h0013 with busy=0. Require `alu_inputR1`=0x000A and `alu_instruction`=3'b011 after E1; `res_valid` after E3 with `res_data`=0x0013, `res_op`=3'b011, `res_err`=0.
- **Busy hold:** the stub holds busy=1 for 5 cycles after ISSUE, then outputR=16'h1234. Require `res_valid` exactly 5 cycles later than the no-busy case, `res_data`=0x1234, and `alu_*` stable throughout.
- **FIFO full:** push 5 commands back-to-back with DEPTH=4 and `res_ready`=0. Require `cmd_ready`=0 once 4 entries are held (first popped), and results delivered in push order once `res_ready`=1.
- **Back-pressure:** hold `res_ready`=0 for 10 cycles after `res_valid`. Require `res_*` stable, no new ALU issue, and IDLE entered the cycle after `res_ready`.
- **Timeout:** the stub holds busy=1 forever, MAX_WAIT=8. Require `res_valid` with `res_err`=1 and `res_data`=0, after which the next queued command issues normally.
- **Reset mid-WAIT:** assert `RST` with 2 commands queued and one in WAIT. Require all outputs at reset values immediately, no `res_valid` after release, and `idle`=1.
